// File: rtl/card_cursor_select.sv
// ============================================================================
// card_cursor_select : button-driven cursor on the 4x4 card grid, with a board
// shadow and a fixed-width Select pulse for face-down cards only.
// Revision: 1.0
// ============================================================================
`default_nettype none

module card_cursor_select #(
  parameter int unsigned SEL_PULSE   = 4,
  parameter logic [5:0]  SHADOW_INIT = 6'b010000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnC,
  input  logic       WriteEnable,
  input  logic [5:0] dataIn,
  input  logic [3:0] dataLoc,
  output logic [3:0] CardSelectLoc,
  output logic [5:0] CardSelectData,
  output logic       Select,
  output logic       Reject
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_e;

  localparam logic [3:0] C_PULSE_LAST = 4'(SEL_PULSE - 1);
  localparam logic [1:0] C_STAT_DOWN  = 2'b01;
  localparam logic [1:0] C_DIR_U      = 2'd0;
  localparam logic [1:0] C_DIR_D      = 2'd1;
  localparam logic [1:0] C_DIR_L      = 2'd2;
  localparam logic [1:0] C_DIR_R      = 2'd3;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] loc_q, loc_d;
  logic       pend_v_q, pend_v_d;
  logic [1:0] pend_dir_q, pend_dir_d;
  logic [5:0] hold_q, hold_d;
  logic       reject_q, reject_d;
  logic [4:0] btn_q;
  logic [5:0] shadow_q [16];

  logic [4:0] w_lvl;
  logic [4:0] w_ev;
  logic       w_mv_v;
  logic [1:0] w_mv_dir;
  logic [5:0] w_byp;

  function automatic logic [3:0] apply_move(input logic [3:0] loc, input logic [1:0] dir);
    logic [1:0] row;
    logic [1:0] col;
    row = loc[3:2];
    col = loc[1:0];
    case (dir)
      C_DIR_U: row = row - 2'd1;
      C_DIR_D: row = row + 2'd1;
      C_DIR_L: col = col - 2'd1;
      default: col = col + 2'd1;
    endcase
    return {row, col};
  endfunction

  // Bit order {U, D, L, R, C}; rising edge against the single registered sample.
  assign w_lvl = {BtnU, BtnD, BtnL, BtnR, BtnC};
  assign w_ev  = w_lvl & ~btn_q;

  always_comb begin
    w_mv_v   = 1'b1;
    w_mv_dir = C_DIR_R;
    if (w_ev[4])      w_mv_dir = C_DIR_U;
    else if (w_ev[3]) w_mv_dir = C_DIR_D;
    else if (w_ev[2]) w_mv_dir = C_DIR_L;
    else if (w_ev[1]) w_mv_dir = C_DIR_R;
    else              w_mv_v   = 1'b0;
  end

  // Same-cycle board write to the cursor cell takes precedence over the shadow.
  assign w_byp = (WriteEnable && (dataLoc == loc_q)) ? dataIn : shadow_q[loc_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loc_d      = loc_q;
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
    hold_d     = hold_q;
    reject_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_mv_v) loc_d = apply_move(loc_q, w_mv_dir);
        if (w_ev[0]) begin
          if (w_byp[5:4] == C_STAT_DOWN) begin
            // A move in the launching cycle is deferred so the selected cell stays put.
            state_d    = ST_PULSE;
            cnt_d      = C_PULSE_LAST;
            hold_d     = w_byp;
            loc_d      = loc_q;
            pend_v_d   = w_mv_v;
            pend_dir_d = w_mv_dir;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      default: begin
        if (w_mv_v) begin
          pend_v_d   = 1'b1;
          pend_dir_d = w_mv_dir;
        end
        if (cnt_q == 4'd0) begin
          state_d  = ST_IDLE;
          pend_v_d = 1'b0;
          if (w_mv_v)        loc_d = apply_move(loc_q, w_mv_dir);
          else if (pend_v_q) loc_d = apply_move(loc_q, pend_dir_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      loc_q      <= 4'd0;
      pend_v_q   <= 1'b0;
      pend_dir_q <= 2'd0;
      hold_q     <= SHADOW_INIT;
      reject_q   <= 1'b0;
      btn_q      <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loc_q      <= loc_d;
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
      hold_q     <= hold_d;
      reject_q   <= reject_d;
      btn_q      <= w_lvl;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) shadow_q[i] <= SHADOW_INIT;
    end else if (WriteEnable) begin
      shadow_q[dataLoc] <= dataIn;
    end
  end

  assign Select         = (state_q == ST_PULSE);
  assign Reject         = reject_q;
  assign CardSelectLoc  = loc_q;
  assign CardSelectData = Select ? hold_q : shadow_q[loc_q];

endmodule

`default_nettype wire
